// File: rtl/adc_gap_pkg.sv
// Shared types and sizing helpers for the ADC gap-voltage monitor.
// Imported by the moving average and the classifier top.
package adc_gap_pkg;

  typedef enum logic [1:0] {
    GAP_NORMAL = 2'd0,
    GAP_SHORT  = 2'd1,
    GAP_OPEN   = 2'd2
  } gap_state_t;

  localparam int DEF_DEBOUNCE = 3;

  // Debounce counter must hold values 0..DEBOUNCE.
  function automatic int dbc_width(input int deb);
    return (deb < 1) ? 1 : $clog2(deb + 1);
  endfunction

  localparam int DBC_W = dbc_width(DEF_DEBOUNCE);

endpackage

// File: rtl/moving_avg.sv
// Circular-buffer moving average over 2**AVG_WIDTH samples.
// valid at t -> sum at t+1 -> avg/avg_valid at t+2.
module moving_avg #(
  parameter int RES_WIDTH = 21,
  parameter int AVG_WIDTH = 3
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [RES_WIDTH-1:0] data,
  input  logic                 valid,
  output logic [RES_WIDTH-1:0] avg,
  output logic                 avg_valid
);

  localparam int N  = 1 << AVG_WIDTH;
  localparam int PW = (AVG_WIDTH > 0) ? AVG_WIDTH : 1;
  localparam int SW = RES_WIDTH + AVG_WIDTH;
  localparam int FW = AVG_WIDTH + 1;

  logic [RES_WIDTH-1:0] r_buf [N];
  logic [PW-1:0]        r_wp;
  logic [SW-1:0]        r_sum;
  logic [FW-1:0]        r_fill;
  logic                 r_sum_vld;

  logic [SW-1:0]        w_sum_next;
  logic                 w_primed;

  // The oldest entry is always part of the sum, so no underflow.
  assign w_sum_next = r_sum + SW'(data) - SW'(r_buf[r_wp]);
  assign w_primed   = (r_fill >= FW'(N - 1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_wp      <= '0;
      r_sum     <= '0;
      r_fill    <= '0;
      r_sum_vld <= 1'b0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else if (sclr) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_wp      <= '0;
      r_sum     <= '0;
      r_fill    <= '0;
      r_sum_vld <= 1'b0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      r_sum_vld <= valid && w_primed;
      if (valid) begin
        r_sum       <= w_sum_next;
        r_buf[r_wp] <= data;
        if (r_wp == PW'(N - 1)) r_wp <= '0;
        else                    r_wp <= r_wp + 1'b1;
        if (r_fill != FW'(N)) r_fill <= r_fill + 1'b1;
      end
      avg_valid <= r_sum_vld;
      if (r_sum_vld) avg <= r_sum[SW-1:AVG_WIDTH];
    end
  end

endmodule

// File: rtl/adc_gap_monitor.sv
// Gap-voltage monitor: moving average plus hysteresis/debounce
// classifier producing NORMAL / SHORT / OPEN interlock flags.
module adc_gap_monitor
  import adc_gap_pkg::*;
#(
  parameter int RES_WIDTH = 21,
  parameter int AVG_WIDTH = 3,
  parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [RES_WIDTH-1:0] data,
  input  logic                 valid,
  input  logic [RES_WIDTH-1:0] short_set,
  input  logic [RES_WIDTH-1:0] short_clr,
  input  logic [RES_WIDTH-1:0] open_set,
  input  logic [RES_WIDTH-1:0] open_clr,
  output logic [RES_WIDTH-1:0] avg,
  output logic                 avg_valid,
  output logic                 short,
  output logic                 open,
  output logic                 changed
);

  localparam int DW = dbc_width(DEBOUNCE);

  logic [RES_WIDTH-1:0] w_avg;
  logic                 w_avg_valid;
  logic                 w_qual;
  gap_state_t           w_tgt;
  logic [DW-1:0]        w_cnt_inc;
  logic                 w_fire;

  gap_state_t           r_state;
  gap_state_t           r_tgt;
  logic [DW-1:0]        r_cnt;
  logic                 r_short;
  logic                 r_open;
  logic                 r_changed;

  moving_avg #(
    .RES_WIDTH (RES_WIDTH),
    .AVG_WIDTH (AVG_WIDTH)
  ) u_avg (
    .clock     (clock),
    .aclr      (aclr),
    .sclr      (sclr),
    .data      (data),
    .valid     (valid),
    .avg       (w_avg),
    .avg_valid (w_avg_valid)
  );

  // SHORT is tested first so it wins with misordered thresholds.
  always_comb begin
    w_qual = 1'b0;
    w_tgt  = GAP_NORMAL;
    unique case (r_state)
      GAP_NORMAL: begin
        if (w_avg < short_set) begin
          w_qual = 1'b1;
          w_tgt  = GAP_SHORT;
        end else if (w_avg > open_set) begin
          w_qual = 1'b1;
          w_tgt  = GAP_OPEN;
        end
      end
      GAP_SHORT: w_qual = (w_avg > short_clr);
      GAP_OPEN:  w_qual = (w_avg < open_clr);
      default: ;
    endcase
  end

  assign w_cnt_inc = (r_cnt != '0 && w_tgt == r_tgt)
                   ? r_cnt + 1'b1 : DW'(1);
  assign w_fire    = w_qual && (w_cnt_inc == DW'(DEBOUNCE));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state   <= GAP_NORMAL;
      r_tgt     <= GAP_NORMAL;
      r_cnt     <= '0;
      r_short   <= 1'b0;
      r_open    <= 1'b0;
      r_changed <= 1'b0;
    end else if (sclr) begin
      r_state   <= GAP_NORMAL;
      r_tgt     <= GAP_NORMAL;
      r_cnt     <= '0;
      r_short   <= 1'b0;
      r_open    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (w_avg_valid) begin
        if (!w_qual) begin
          r_cnt <= '0;
        end else if (w_fire) begin
          r_state   <= w_tgt;
          r_short   <= (w_tgt == GAP_SHORT);
          r_open    <= (w_tgt == GAP_OPEN);
          r_changed <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
          r_tgt <= w_tgt;
        end
      end
    end
  end

  assign avg       = w_avg;
  assign avg_valid = w_avg_valid;
  assign short     = r_short;
  assign open      = r_open;
  assign changed   = r_changed;

endmodule

// File: doc/adc_gap_monitor.md
# adc_gap_monitor

Gap-voltage monitor that sits directly downstream of the sigma-delta CIC decimator. It consumes the decimator's `data`/`valid` sample stream, forms a 2**AVG_WIDTH-sample moving average, and classifies the averaged gap voltage as NORMAL, SHORT or OPEN. Classification uses hysteresis thresholds and consecutive-sample debounce. Its flags drive the generator/motion interlock logic.

## Interface
Parameters:
- RES_WIDTH, 21: sample width; matches decimator output.
- AVG_WIDTH, 3: averaging window is 2**AVG_WIDTH samples; range 0..6.
- DEBOUNCE, 3: number of consecutive qualifying averages required to change state; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- aclr  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear; same effect as aclr, applied at the clock edge.
- data  in  RES_WIDTH  unsigned sample from the decimator.
- valid  in  1  one-cycle strobe qualifying `data`.
- short_set, short_clr  in  RES_WIDTH each  SHORT entry / exit thresholds.
- open_set, open_clr  in  RES_WIDTH each  OPEN entry / exit thresholds.
- avg  out  RES_WIDTH  current window average.
- avg_valid  out  1  one-cycle strobe qualifying `avg`.
- short  out  1  state is SHORT.
- open  out  1  state is OPEN.
- changed  out  1  one-cycle pulse on every state change.

## Operation
- **Reset/clear:** the window buffer, running sum, fill counter, debounce counter and all outputs go to 0. State goes to NORMAL.
- **Window:** circular buffer of 2**AVG_WIDTH entries with a write pointer that wraps at 2**AVG_WIDTH.
  - On `valid`: sum <= sum + data − buf[wp]; buf[wp] <= data; wp++.
  - sum width is RES_WIDTH+AVG_WIDTH, so it never overflows.
  - avg = sum >> AVG_WIDTH (truncating).
- **Priming:** a fill counter saturates once 2**AVG_WIDTH samples have been accepted. `avg_valid` stays low until then. After priming, `avg_valid` pulses once per input `valid`.
- **Threshold qualification** (each state evaluates only on `avg_valid`):
  - NORMAL:
    - avg < short_set qualifies toward SHORT.
    - Otherwise, avg > open_set qualifies toward OPEN.
    - SHORT has priority when both hold (misordered thresholds).
  - SHORT: avg > short_clr qualifies toward NORMAL.
  - OPEN: avg < open_clr qualifies toward NORMAL.
- **Debounce counter:**
  - Increments on each qualifying average with the same target.
  - Clears on a non-qualifying average, on a change of target, or on a state transition.
  - The transition fires on the DEBOUNCE-th consecutive qualifying average.
- **Allowed transitions:** SHORT and OPEN exit only to NORMAL. There is no direct SHORT↔OPEN transition; a jump takes at least 2·DEBOUNCE averages.
- **Output flags:** `short`, `open` and `changed` are registered decodes of the state. `changed` is high for exactly one cycle per transition.
- **Threshold inputs:** quasi-static. They are sampled on the `avg_valid` cycle, and a change takes effect from the next average.

## Timing
- `valid` at cycle t → sum/buffer updated at t+1 → `avg` and `avg_valid` at t+2.
- State register, `short`/`open` and `changed` update at t+3.
- `valid` may arrive on back-to-back cycles; all stages are fully pipelined at one sample per clock.
- `avg` holds its value between strobes.
- sclr has priority over `valid` in the same cycle; that sample is discarded.
- aclr or sclr mid-window discards partial history, and re-priming requires 2**AVG_WIDTH fresh samples.
- AVG_WIDTH=0: avg = data, and the block is primed after the first sample.

## Structure
- Shared package `adc_gap_pkg`: state typedef `gap_state_t` {GAP_NORMAL, GAP_SHORT, GAP_OPEN}, plus a `clog2`-based width constant for the debounce counter.
- One natural sub-module, `moving_avg`: buffer, sum, fill counter and avg/avg_valid pipeline. The classifier state machine stays in the top module.

## Test plan
Default parameters throughout: RES_WIDTH=21, AVG_WIDTH=3, DEBOUNCE=3. Thresholds: short_set=1000, short_clr=1200, open_set=50000, open_clr=45000.

- **Priming:** 8 samples of 20000 → no `avg_valid` for samples 1–7; sample 8 gives avg=20000 at t+2. Flags stay 0.
- **SHORT entry:** after priming, feed 0s.
  - Averages 17500, …, 0 result.
  - `short` rises on the 3rd consecutive average below 1000, with `changed` pulsing one cycle at the same time.
  - One intervening average of 5000 resets the debounce count.
- **Hysteresis:** from SHORT, hold avg=1100 → `short` stays 1. Three averages of 1300 → NORMAL, with `changed` pulsing.
- **No direct SHORT→OPEN:** from SHORT, feed 60000s → NORMAL after 3 qualifying averages, then OPEN after 3 more.
- **Reset mid-window:** assert aclr after 5 samples → all outputs 0 immediately. The next 7 samples give no `avg_valid`. Also assert sclr together with `valid` → that sample is not counted.
- **Max value / back-to-back:** `valid` on every cycle with data=2**21−1 → avg=2097151 with no overflow, one `avg_valid` per clock after priming, and `open` set.
